// File: rtl/io_pkg.sv
// I/O bus types, UART register offsets, status bit positions and UART FSM encodings.
// Latency: none, declarations only.
// Backpressure: not applicable.
package io_pkg;

    typedef enum logic [1:0] {
        IO_NONE  = 2'd0,
        IO_READ  = 2'd1,
        IO_WRITE = 2'd2
    } io_mode_t;

    localparam logic [31:0] UART_DATA_OFS   = 32'd0;
    localparam logic [31:0] UART_STATUS_OFS = 32'd4;

    localparam int ST_TX_NFULL  = 0;
    localparam int ST_RX_NEMPTY = 1;
    localparam int ST_OVR_RX    = 2;
    localparam int ST_OVR_TX    = 3;
    localparam int ST_TX_IDLE   = 4;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head; pointers carry one wrap bit.
// Latency: a push is visible at dout/empty the cycle after its edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_serial.sv
// 8N1 UART on the CPU I/O bus: TX FIFO -> transmitter, receiver -> RX FIFO; UART_LOOPBACK_EN ties RX to TX.
// Latency: write to start bit 2 cycles; stop-bit sample to RX-not-empty 1 cycle; reads combinational.
// Backpressure: none on the bus; writes to a full TX FIFO and bytes into a full RX FIFO drop and set sticky flags.
module uart_serial
    import io_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rxd,
    output logic        txd
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    logic rd_op, wr_op, is_stat, stat_rd;
    logic tx_push, tx_pop, tx_full, tx_empty;
    logic rx_pop, rx_full, rx_empty;
    logic [7:0] tx_dout, rx_dout;
    logic [31:0] status;
    logic ovr_tx_q, ovr_tx_d, ovr_rx_q, ovr_rx_d;
    logic unused_bus;

    uart_state_t tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          txd_q, txd_d;

    uart_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_push_q, rx_push_d;
    logic          rx_src, s1_q, s2_q, s3_q;

    assign unused_bus = &{1'b0, addr[31:3], addr[1:0], wdata[31:8]};

    assign rd_op   = (mode == IO_READ);
    assign wr_op   = (mode == IO_WRITE);
    assign is_stat = addr[2];
    assign stat_rd = rd_op && is_stat;
    assign tx_push = wr_op && !is_stat;
    assign rx_pop  = rd_op && !is_stat && !rx_empty;

    always_comb begin
        status = '0;
        status[ST_TX_NFULL]  = !tx_full;
        status[ST_RX_NEMPTY] = !rx_empty;
        status[ST_OVR_RX]    = ovr_rx_q;
        status[ST_OVR_TX]    = ovr_tx_q;
        status[ST_TX_IDLE]   = tx_empty && (tx_state_q == U_IDLE);
        rdata = '0;
        if (stat_rd)     rdata = status;
        else if (rx_pop) rdata = {24'd0, rx_dout};
    end

    // Set wins over the read-clear so an overflow on the reading edge is not lost.
    assign ovr_tx_d = (tx_push && tx_full && !tx_pop) || (ovr_tx_q && !stat_rd);
    assign ovr_rx_d = (rx_push_q && rx_full && !rx_pop) || (ovr_rx_q && !stat_rd);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push_q), .pop(rx_pop), .din(rx_sh_q),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            U_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_dout;
                    tx_state_d = U_START;
                end
            end
            U_START: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = U_DATA;
            end
            U_DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 1'b1;
                if (tx_bit_q == 3'd7) tx_state_d = U_STOP;
            end
            default: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = U_IDLE;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_dout;
                    tx_state_d = U_START;
                end
            end
        endcase
        case (tx_state_q)
            U_START: txd_d = 1'b0;
            U_DATA:  txd_d = tx_sh_q[0];
            default: txd_d = 1'b1;
        endcase
    end

`ifdef UART_LOOPBACK_EN
    assign rx_src = txd_q;
`else
    assign rx_src = rxd;
    // rxd only feeds the synchroniser in the default build.
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push_d  = 1'b0;
        case (rx_state_q)
            U_IDLE: begin
                rx_cnt_d = '0;
                if (s3_q && !s2_q) rx_state_d = U_START;
            end
            U_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = s2_q ? U_IDLE : U_DATA;
            end
            U_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = U_STOP;
            end
            default: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_push_d  = s2_q;
                rx_state_d = U_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= U_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= U_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_push_q  <= 1'b0;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            ovr_tx_q   <= 1'b0;
            ovr_rx_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_push_q  <= rx_push_d;
            s1_q       <= rx_src;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            ovr_tx_q   <= ovr_tx_d;
            ovr_rx_q   <= ovr_rx_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_uart_serial.sv
// Directed bench for uart_serial at CLK_DIV = 8, FIFO_DEPTH = 16.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 unit after the rising edge.
module tb_uart_serial;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] addr, wdata, rdata;
    logic        rxd, txd;

    int tests = 0;
    int fails = 0;
    logic [31:0] d;
    logic        txrec [0:1409];

    always #5 clk = ~clk;

    uart_serial #(.CLK_DIV(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rxd(rxd), .txd(txd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        mode = 2'd1;
        addr = a;
        #1 v = rdata;
        @(posedge clk);
        #1 mode = 2'd0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        mode  = 2'd2;
        addr  = a;
        wdata = w;
        @(posedge clk);
        #1 mode = 2'd0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (8) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_txd_idle(input string tag, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; addr = '0; wdata = '0; rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        bus_rd(32'd4, d);
        chk("reset_status", d, 32'h11);
        check_txd_idle("txd_idle_100", 100);

`ifdef UART_LOOPBACK_EN
        bus_wr(32'd0, 32'h52);
        repeat (95) @(negedge clk);
        bus_rd(32'd4, d);
        chk("lb_status", d, 32'h13);
        bus_rd(32'd0, d);
        chk("lb_data", d, 32'h52);
        bus_rd(32'd4, d);
        chk("lb_status_after", d, 32'h11);
`else
        // 0x47 on txd: start low 2 cycles after the write edge, LSB first, 8-cycle pitch.
        begin
            logic [7:0] g;
            g = 8'h47;
            bus_wr(32'd0, 32'h47);
            @(negedge clk);
            @(negedge clk);
            chk("tx_pre_start", {31'd0, txd}, 32'd1);
            @(negedge clk);
            chk("tx_start_edge", {31'd0, txd}, 32'd0);
            repeat (4) @(negedge clk);
            chk("tx_start_mid", {31'd0, txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (8) @(negedge clk);
                chk($sformatf("tx_bit%0d", i), {31'd0, txd}, {31'd0, g[i]});
            end
            repeat (8) @(negedge clk);
            chk("tx_stop", {31'd0, txd}, 32'd1);
            repeat (12) @(negedge clk);
            bus_rd(32'd4, d);
            chk("tx_done_status", d, 32'h11);
        end

        send_rx(8'h00, 1'b1);
        send_rx(8'h20, 1'b1);
        send_rx(8'h80, 1'b1);
        repeat (4) @(negedge clk);
        bus_rd(32'd4, d);
        chk("rx3_status", d, 32'h13);
        bus_rd(32'd0, d);
        chk("rx_data0", d, 32'h00);
        bus_rd(32'd0, d);
        chk("rx_data1", d, 32'h20);
        bus_rd(32'd0, d);
        chk("rx_data2", d, 32'h80);
        bus_rd(32'd0, d);
        chk("rx_data_empty", d, 32'h00);
        bus_rd(32'd4, d);
        chk("rx_empty_status", d, 32'h11);

        // One byte keeps the transmitter busy while 17 more are written; the 17th must drop.
        bus_wr(32'd0, 32'hAA);
        fork
            begin
                for (int i = 0; i < 1410; i++) begin
                    @(negedge clk);
                    txrec[i] = txd;
                end
            end
            begin
                repeat (4) @(posedge clk);
                for (int k = 0; k < 17; k++) bus_wr(32'd0, 32'(32'h30 + k));
                bus_rd(32'd4, d);
                chk("ovr_tx_set", d, 32'h08);
                bus_rd(32'd4, d);
                chk("ovr_tx_clear", d, 32'h00);
            end
        join
        for (int k = 0; k < 17; k++) begin
            logic [7:0] b;
            logic [9:0] got;
            b = (k == 0) ? 8'hAA : 8'(8'h30 + k - 1);
            for (int j = 0; j < 10; j++) got[j] = txrec[2 + 80 * k + 8 * j + 4];
            chk($sformatf("burst_frame%0d", k), {22'd0, got}, {22'd0, 1'b1, b, 1'b0});
        end
        begin
            int bad;
            bad = 0;
            for (int i = 1362; i < 1410; i++) if (txrec[i] !== 1'b1) bad++;
            chk("burst_no_extra", bad, 0);
        end
        bus_rd(32'd4, d);
        chk("burst_done_status", d, 32'h11);

        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        bus_rd(32'd4, d);
        chk("glitch_status", d, 32'h11);
        send_rx(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        bus_rd(32'd4, d);
        chk("framing_status", d, 32'h11);
        send_rx(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        bus_rd(32'd0, d);
        chk("rx_after_errors", d, 32'hC3);
`endif

        // Reset in the middle of a 0x00 frame with two more bytes queued.
        bus_wr(32'd0, 32'h00);
        bus_wr(32'd0, 32'h00);
        bus_wr(32'd0, 32'h00);
        repeat (30) @(negedge clk);
        chk("tx_midframe", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("rst_txd_high", {31'd0, txd}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_rd(32'd4, d);
        chk("rst_status", d, 32'h11);
        bus_rd(32'd0, d);
        chk("rst_rx_empty", d, 32'h00);
        check_txd_idle("rst_tx_fifo_empty", 100);
        bus_rd(32'd4, d);
        chk("rst_status_final", d, 32'h11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
